ifu_fetch_queue: RTL and testbench

- Instruction fetch front end. Owns the PC, issues in-order requests to instruction memory, and buffers returned instructions with their PCs.
- Presents one {pc, inst} pair per cycle to the decode stage over a valid/ready handshake.
- Redirects from branch/jump resolution flush the buffer, discard stale in-flight responses and restart fetch at the target.

---
 rtl/ifu_fetch_queue.sv | 132 +++++++++++++
 tb/tb_ifu_fetch_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues in-order memory requests and
// buffers returned instructions for decode, with redirect flush and stale-response dropping.
module ifu_fetch_queue #(
    parameter int               XLEN     = 64,
    parameter int               ILEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_8000_0000,
    parameter int               FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc
);

    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ILEN-1:0] NOP_INST = ILEN'(32'h0000_0013);

    logic [XLEN-1:0] fetch_pc_reg;

    logic [XLEN-1:0] fq_pc_mem   [FQ_DEPTH];
    logic [ILEN-1:0] fq_inst_mem [FQ_DEPTH];
    logic [PW-1:0]   fq_rd_ptr_reg;
    logic [PW-1:0]   fq_wr_ptr_reg;
    logic [CW-1:0]   fq_cnt_reg;

    logic [XLEN-1:0] pf_mem [FQ_DEPTH];
    logic [PW-1:0]   pf_rd_ptr_reg;
    logic [PW-1:0]   pf_wr_ptr_reg;

    logic [CW-1:0]   osd_reg;
    logic [CW-1:0]   drop_cnt_reg;

    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_fire;
    logic            rsp_keep;
    logic            id_fire;
    logic [XLEN-1:0] redirect_aligned;

    // Buffered entries plus in-flight requests may never exceed the queue depth,
    // so every response is guaranteed a slot.
    assign credit_used      = {1'b0, fq_cnt_reg} + {1'b0, osd_reg};
    assign imem_req_valid   = !rst && !redirect_valid && (credit_used < (CW+1)'(FQ_DEPTH));
    assign imem_req_addr    = fetch_pc_reg;
    assign req_fire         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire         = imem_rsp_valid && (osd_reg != '0);
    assign rsp_keep         = rsp_fire && (drop_cnt_reg == '0) && !redirect_valid;

    assign id_valid         = !rst && (fq_cnt_reg != '0);
    assign id_inst          = id_valid ? fq_inst_mem[fq_rd_ptr_reg] : NOP_INST;
    assign id_pc            = id_valid ? fq_pc_mem[fq_rd_ptr_reg] : '0;
    assign id_fire          = id_valid && id_ready && !redirect_valid;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg  <= RESET_PC;
            fq_rd_ptr_reg <= '0;
            fq_wr_ptr_reg <= '0;
            fq_cnt_reg    <= '0;
            pf_rd_ptr_reg <= '0;
            pf_wr_ptr_reg <= '0;
            osd_reg       <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_reg <= redirect_aligned;
            end else if (req_fire) begin
                fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
            end

            // The in-flight PC FIFO survives redirects: dropped responses still pop it.
            if (req_fire) begin
                pf_wr_ptr_reg <= pf_wr_ptr_reg + PW'(1);
            end
            if (rsp_fire) begin
                pf_rd_ptr_reg <= pf_rd_ptr_reg + PW'(1);
            end
            osd_reg <= osd_reg + CW'(req_fire) - CW'(rsp_fire);

            if (redirect_valid) begin
                drop_cnt_reg <= osd_reg - CW'(rsp_fire);
            end else if (rsp_fire && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - CW'(1);
            end

            if (redirect_valid) begin
                fq_rd_ptr_reg <= '0;
                fq_wr_ptr_reg <= '0;
                fq_cnt_reg    <= '0;
            end else begin
                if (rsp_keep) begin
                    fq_wr_ptr_reg <= fq_wr_ptr_reg + PW'(1);
                end
                if (id_fire) begin
                    fq_rd_ptr_reg <= fq_rd_ptr_reg + PW'(1);
                end
                fq_cnt_reg <= fq_cnt_reg + CW'(rsp_keep) - CW'(id_fire);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            fq_pc_mem[fq_wr_ptr_reg]   <= pf_mem[pf_rd_ptr_reg];
            fq_inst_mem[fq_wr_ptr_reg] <= imem_rsp_data;
        end
        if (req_fire) begin
            pf_mem[pf_wr_ptr_reg] <= fetch_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid) begin
            assert (osd_reg != '0);
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Randomized scoreboard bench for ifu_fetch_queue: a memory model with in-order variable
// latency, and an expected {pc, inst} stream rebuilt from every reset/redirect target.
module tb_ifu_fetch_queue;

    localparam int XLEN     = 64;
    localparam int ILEN     = 32;
    localparam int FQ_DEPTH = 2;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

    logic            clk            = 1'b0;
    logic            rst            = 1'b1;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [ILEN-1:0] imem_rsp_data  = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc    = '0;
    logic            id_valid;
    logic            id_ready       = 1'b0;
    logic [ILEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;

    ifu_fetch_queue #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] addr;
        int              due;
    } mreq_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } exp_t;

    int              vectors     = 0;
    int              miscompares = 0;
    int              cyc         = 0;
    int              accepts     = 0;
    int              pops        = 0;
    int              ready_mode  = 0;
    int              lat_min     = 1;
    int              lat_max     = 1;
    bit              track       = 1'b0;
    int              first_acc   = -1;
    int              first_vld   = -1;
    mreq_t           mem_q[$];
    exp_t            exp_q[$];
    logic [XLEN-1:0] exp_tail;
    logic [XLEN-1:0] exp_fetch;

    logic            prev_rst   = 1'b1;
    logic            prev_redir = 1'b0;
    logic            prev_idv   = 1'b0;
    logic            prev_idr   = 1'b0;
    logic            prev_reqv  = 1'b0;
    logic            prev_reqr  = 1'b0;
    logic [XLEN-1:0] prev_addr  = '0;
    logic [XLEN-1:0] prev_pc    = '0;
    logic [ILEN-1:0] prev_inst  = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h5a3c_96e1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected decode stream: consecutive word addresses from the last restart point.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: exp_tail, inst: inst_of(exp_tail)});
            exp_tail = exp_tail + 64'd4;
        end
    endtask

    task automatic restart(input logic [XLEN-1:0] target);
        exp_q.delete();
        exp_tail  = target;
        exp_fetch = target;
        topup();
    endtask

    // redir_mode: 0 none, 1 always, 2 only when a response is returned this cycle.
    task automatic drive_cycle(input bit do_rst, input int redir_mode, input logic [XLEN-1:0] rpc,
                               input bit idr, output bit redirected);
        @(posedge clk);
        #1;
        rst      = do_rst;
        id_ready = idr;
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = ~imem_req_ready;
            default: imem_req_ready = 1'($urandom_range(0, 1));
        endcase
        if (do_rst) mem_q.delete();
        if (!do_rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        redirected     = !do_rst && (redir_mode == 1 || (redir_mode == 2 && imem_rsp_valid));
        redirect_valid = redirected;
        redirect_pc    = rpc;
        if (do_rst) restart(RESET_PC);
        else if (redirected) restart({rpc[XLEN-1:2], 2'b00});
        topup();
    endtask

    task automatic run(input int n, input bit idr);
        bit r;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, '0, idr, r);
    endtask

    task automatic do_reset(input int n);
        bit r;
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 0, '0, 1'b0, r);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on each decode handshake.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check("rst_id_valid", 64'(id_valid), 64'd0);
            check("rst_id_inst", 64'(id_inst), 64'(NOP));
            check("rst_id_pc", id_pc, 64'd0);
        end else begin
            if (prev_rst || prev_redir) check("flush_id_valid", 64'(id_valid), 64'd0);
            if (!id_valid) begin
                check("empty_id_inst", 64'(id_inst), 64'(NOP));
                check("empty_id_pc", id_pc, 64'd0);
            end
            if (prev_idv && !prev_idr && !prev_redir) begin
                check("hold_id_valid", 64'(id_valid), 64'd1);
                check("hold_id_pc", id_pc, prev_pc);
                check("hold_id_inst", 64'(id_inst), 64'(prev_inst));
            end
            if (prev_reqv && !prev_reqr) check("req_addr_stable", imem_req_addr, prev_addr);
            if (imem_req_valid) check("req_addr_align", 64'(imem_req_addr[1:0]), 64'd0);
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_fetch);
                exp_fetch = exp_fetch + 64'd4;
                mem_q.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
                accepts++;
                if (track && first_acc < 0) first_acc = cyc;
            end
            if (track && first_vld < 0 && id_valid) first_vld = cyc;
            if (id_valid && id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    $display("deliver pc=%h inst=%h expect pc=%h inst=%h",
                             id_pc, id_inst, exp_q[0].pc, exp_q[0].inst);
                    check("id_pc", id_pc, exp_q[0].pc);
                    check("id_inst", 64'(id_inst), 64'(exp_q[0].inst));
                    void'(exp_q.pop_front());
                end
                pops++;
            end
            check("outstanding_le_depth", 64'(mem_q.size() <= FQ_DEPTH), 64'd1);
        end
        prev_rst   = rst;
        prev_redir = redirect_valid;
        prev_idv   = id_valid;
        prev_idr   = id_ready;
        prev_reqv  = imem_req_valid;
        prev_reqr  = imem_req_ready;
        prev_addr  = imem_req_addr;
        prev_pc    = id_pc;
        prev_inst  = id_inst;
    end

    initial begin
        bit r;
        int a0;
        int p0;
        int rnd;
        restart(RESET_PC);

        // Zero-wait memory, 1-cycle latency: first delivery two cycles after first accept.
        ready_mode = 0; lat_min = 1; lat_max = 1;
        do_reset(3);
        track = 1'b1;
        p0 = pops;
        run(12, 1'b1);
        @(negedge clk); #1;
        track = 1'b0;
        check("first_fetch_latency", 64'(first_vld - first_acc), 64'd2);
        check("fill_deliveries", 64'(pops - p0), 64'd7);

        // Decode stalled: only two requests fit, head held at the reset PC.
        do_reset(1);
        a0 = accepts;
        run(10, 1'b0);
        @(negedge clk); #1;
        check("stall_accepts", 64'(accepts - a0), 64'd2);
        check("stall_head_valid", 64'(id_valid), 64'd1);
        check("stall_head_pc", id_pc, RESET_PC);
        check("stall_req_valid", 64'(imem_req_valid), 64'd0);
        run(8, 1'b1);

        // Redirect with requests in flight: their responses must never reach decode.
        lat_min = 3; lat_max = 3;
        run(6, 1'b1);
        drive_cycle(1'b0, 1, 64'h0000_0000_8000_1000, 1'b1, r);
        p0 = pops;
        run(14, 1'b1);
        check("redirect_progress", 64'(pops > p0), 64'd1);

        // Misaligned redirect landing on a response cycle.
        lat_min = 1; lat_max = 1;
        r = 1'b0;
        for (int i = 0; i < 20 && !r; i++) drive_cycle(1'b0, 2, 64'h0000_0000_8000_0102, 1'b1, r);
        check("redirect_on_rsp_hit", 64'(r), 64'd1);
        p0 = pops;
        run(10, 1'b1);
        check("aligned_redirect_progress", 64'(pops > p0), 64'd1);

        // Reset with the queue full.
        run(8, 1'b0);
        do_reset(1);
        run(8, 1'b1);

        // Ready toggling with 3-cycle latency.
        ready_mode = 1; lat_min = 3; lat_max = 3;
        p0 = pops;
        run(60, 1'b1);
        check("toggle_progress", 64'(pops > p0 + 5), 64'd1);

        // Randomized traffic with redirects and occasional resets.
        ready_mode = 2; lat_min = 1; lat_max = 4;
        p0 = pops;
        for (int i = 0; i < 2000; i++) begin
            rnd = int'($urandom_range(0, 199));
            if (rnd == 0) begin
                drive_cycle(1'b1, 0, '0, 1'b0, r);
            end else if (rnd < 10) begin
                drive_cycle(1'b0, 1, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), r);
            end else begin
                drive_cycle(1'b0, 0, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), r);
            end
        end
        ready_mode = 0;
        run(20, 1'b1);
        @(negedge clk); #1;
        check("random_progress", 64'(pops - p0 > 100), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
